// File: rtl/ring_flasher_param.sv
// rtl/ring_flasher_param.sv - parametrised ring flasher: fill/drain arc growth, whole-ring flash, re-arm
module ring_flasher_param #(
    parameter int N_LEDS      = 16,
    parameter int ON_COUNT    = 8,
    parameter int OFF_COUNT   = 4,
    parameter int TICK_DIV    = 1,
    parameter int FLASH_TICKS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        repeat_signal,
    input  logic                        dir,
    input  logic                        stop,
    output logic [N_LEDS-1:0]           led,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(N_LEDS+1)-1:0] lit_count
);
    localparam int HW  = $clog2(N_LEDS);
    localparam int CW  = $clog2(N_LEDS + 1);
    localparam int PW  = $clog2(ON_COUNT + 1);
    localparam int FW  = $clog2(FLASH_TICKS + 1);
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [HW-1:0] HEAD_MAX   = HW'(N_LEDS - 1);
    localparam logic [CW-1:0] LIT_FULL   = CW'(N_LEDS);
    localparam logic [PW-1:0] PH_ON      = PW'(ON_COUNT);
    localparam logic [PW-1:0] PH_OFF     = PW'(OFF_COUNT);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_TICKS);
    localparam logic [TW-1:0] PRES_LAST  = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, FLASH} state_t;

    state_t             r_state, w_state;
    logic [N_LEDS-1:0]  r_led, w_led;
    logic [HW-1:0]      r_head, w_head;
    logic [CW-1:0]      r_lit, w_lit;
    logic [PW-1:0]      r_phase, w_phase;
    logic [FW-1:0]      r_flash, w_flash;
    logic [TW-1:0]      r_pres, w_pres;
    logic               r_dir, w_dir;
    logic               r_done, w_done;
    logic               w_tick;
    logic [HW-1:0]      w_back;

    // up=1 moves toward higher indices, wrapping at the ring ends
    function automatic logic [HW-1:0] step_head(input logic [HW-1:0] h, input logic up);
        if (up) return (h == HEAD_MAX) ? '0 : h + 1'b1;
        else    return (h == '0) ? HEAD_MAX : h - 1'b1;
    endfunction

    assign w_tick = (r_pres == PRES_LAST);
    assign w_back = step_head(r_head, r_dir);

    always_comb begin
        w_state = r_state;
        w_led   = r_led;
        w_head  = r_head;
        w_lit   = r_lit;
        w_phase = r_phase;
        w_flash = r_flash;
        w_dir   = r_dir;
        w_done  = 1'b0;
        w_pres  = w_tick ? '0 : r_pres + 1'b1;

        unique case (r_state)
            IDLE: begin
                w_led  = '0;
                w_lit  = '0;
                w_pres = '0;
                if (repeat_signal) begin
                    w_dir   = dir;
                    w_head  = '0;
                    w_phase = '0;
                    w_state = FILL;
                end
            end
            FILL: if (w_tick) begin
                w_led[r_head] = 1'b1;
                w_head  = step_head(r_head, ~r_dir);
                w_lit   = r_lit + 1'b1;
                w_phase = r_phase + 1'b1;
                if (r_lit + 1'b1 == LIT_FULL) begin
                    w_state = FLASH;
                    w_lit   = '0;
                    w_phase = '0;
                    w_flash = '0;
                end else if (r_phase + 1'b1 == PH_ON) begin
                    w_phase = '0;
                    w_state = DRAIN;
                end
            end
            DRAIN: if (w_tick) begin
                w_head        = w_back;
                w_led[w_back] = 1'b0;
                w_lit         = r_lit - 1'b1;
                w_phase       = r_phase + 1'b1;
                if (r_phase + 1'b1 == PH_OFF) begin
                    w_phase = '0;
                    w_state = FILL;
                end
            end
            FLASH: begin
                // the cycle after the last toggle carries done; leave on the following edge
                if (r_flash == FLASH_LAST) begin
                    w_led = '0;
                    if (repeat_signal) begin
                        w_dir   = dir;
                        w_head  = '0;
                        w_lit   = '0;
                        w_phase = '0;
                        w_state = FILL;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (w_tick) begin
                    w_led   = ~r_led;
                    w_flash = r_flash + 1'b1;
                    w_done  = (r_flash + 1'b1 == FLASH_LAST);
                end
            end
            default: w_state = IDLE;
        endcase

        if (stop && r_state != IDLE) begin
            w_state = IDLE;
            w_led   = '0;
            w_lit   = '0;
            w_phase = '0;
            w_flash = '0;
            w_done  = 1'b0;
        end

        if (w_state != r_state || r_state == FLASH && r_flash == FLASH_LAST)
            w_pres = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_led   <= '0;
            r_head  <= '0;
            r_lit   <= '0;
            r_phase <= '0;
            r_flash <= '0;
            r_pres  <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_led   <= w_led;
            r_head  <= w_head;
            r_lit   <= w_lit;
            r_phase <= w_phase;
            r_flash <= w_flash;
            r_pres  <= w_pres;
            r_dir   <= w_dir;
            r_done  <= w_done;
        end
    end

    assign led       = r_led;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign lit_count = r_lit;
endmodule

// File: tb/tb_ring_flasher_param.sv
// tb/tb_ring_flasher_param.sv - directed table-driven bench for ring_flasher_param
module tb_ring_flasher_param;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        repeat_signal = 1'b0;
    logic        dir = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] led1, led3;
    logic        busy1, busy3, done1, done3;
    logic [4:0]  lit1, lit3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ring_flasher_param dut (
        .clk(clk), .rst(rst), .repeat_signal(repeat_signal), .dir(dir), .stop(stop),
        .led(led1), .busy(busy1), .done(done1), .lit_count(lit1)
    );

    ring_flasher_param #(.TICK_DIV(3)) dut3 (
        .clk(clk), .rst(rst), .repeat_signal(repeat_signal), .dir(dir), .stop(stop),
        .led(led3), .busy(busy3), .done(done3), .lit_count(lit3)
    );

    typedef struct {
        int          e;
        logic [15:0] led;
        logic        busy;
        logic        done;
        logic [4:0]  lit;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive the run request so it is sampled at the next edge (edge k), then drop it
    task automatic start();
        repeat_signal = 1'b1;
        step();
        repeat_signal = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy1 || busy3) && n < 400) begin
            step();
            n++;
        end
        check("idle_wait", {30'd0, busy1, busy3}, 32'd0);
    endtask

    initial begin
        int idx;
        int dones;

        tbl[0]  = '{0,  16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[1]  = '{1,  16'h0001, 1'b1, 1'b0, 5'd1};
        tbl[2]  = '{8,  16'h00FF, 1'b1, 1'b0, 5'd8};
        tbl[3]  = '{9,  16'h007F, 1'b1, 1'b0, 5'd7};
        tbl[4]  = '{12, 16'h000F, 1'b1, 1'b0, 5'd4};
        tbl[5]  = '{20, 16'h0FFF, 1'b1, 1'b0, 5'd12};
        tbl[6]  = '{24, 16'h00FF, 1'b1, 1'b0, 5'd8};
        tbl[7]  = '{31, 16'h7FFF, 1'b1, 1'b0, 5'd15};
        tbl[8]  = '{32, 16'hFFFF, 1'b1, 1'b0, 5'd0};
        tbl[9]  = '{33, 16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[10] = '{34, 16'hFFFF, 1'b1, 1'b0, 5'd0};
        tbl[11] = '{35, 16'h0000, 1'b1, 1'b0, 5'd0};
        tbl[12] = '{36, 16'hFFFF, 1'b1, 1'b1, 5'd0};
        tbl[13] = '{37, 16'h0000, 1'b0, 1'b0, 5'd0};

        // reset held with a pending run request
        rst = 1'b1;
        repeat_signal = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset_led", {16'd0, led1}, 32'd0);
            check("reset_busy", {31'd0, busy1}, 32'd0);
            check("reset_done", {31'd0, done1}, 32'd0);
        end
        check("reset_lit", {27'd0, lit1}, 32'd0);
        rst = 1'b0;
        repeat_signal = 1'b0;
        step();
        check("idle_after_reset", {31'd0, busy1}, 32'd0);

        // full ascending run against the table
        start();
        idx = 0;
        dones = 0;
        for (int e = 0; e <= 40; e++) begin
            if (e > 0) step();
            if (done1) dones++;
            if (idx < 14 && tbl[idx].e == e) begin
                check($sformatf("run_led_e%0d", e), {16'd0, led1}, {16'd0, tbl[idx].led});
                check($sformatf("run_busy_e%0d", e), {31'd0, busy1}, {31'd0, tbl[idx].busy});
                check($sformatf("run_done_e%0d", e), {31'd0, done1}, {31'd0, tbl[idx].done});
                check($sformatf("run_lit_e%0d", e), {27'd0, lit1}, {27'd0, tbl[idx].lit});
                idx++;
            end
        end
        check("run_done_count", dones, 1);
        wait_idle();

        // descending run: arc wraps from 0 down through 15
        dir = 1'b1;
        start();
        dir = 1'b0;
        repeat (3) step();
        check("dir1_led_k3", {16'd0, led1}, 32'h0000C001);
        repeat (5) step();
        check("dir1_led_k8", {16'd0, led1}, 32'h0000FE01);
        check("dir1_lit_k8", {27'd0, lit1}, 32'd8);
        wait_idle();

        // prescaler of 3 on the second instance
        start();
        for (int e = 1; e <= 96; e++) begin
            step();
            if (e == 2)  check("div3_led_k2", {16'd0, led3}, 32'd0);
            if (e == 3)  check("div3_led_k3", {16'd0, led3}, 32'h00000001);
            if (e == 3)  check("div3_lit_k3", {27'd0, lit3}, 32'd1);
            if (e == 95) check("div3_led_k95", {16'd0, led3}, 32'h00007FFF);
            if (e == 96) check("div3_led_k96", {16'd0, led3}, 32'h0000FFFF);
        end
        wait_idle();

        // re-arm with the request held high
        repeat_signal = 1'b1;
        step();
        for (int e = 1; e <= 38; e++) begin
            step();
            if (e == 36) check("rearm_done_k36", {31'd0, done1}, 32'd1);
            if (e == 37) begin
                check("rearm_led_k37", {16'd0, led1}, 32'd0);
                check("rearm_busy_k37", {31'd0, busy1}, 32'd1);
                check("rearm_done_k37", {31'd0, done1}, 32'd0);
                check("rearm_lit_k37", {27'd0, lit1}, 32'd0);
            end
            if (e == 38) check("rearm_led_k38", {16'd0, led1}, 32'h00000001);
        end
        repeat_signal = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("rearm_stop_busy", {31'd0, busy1}, 32'd0);
        check("rearm_stop_led", {16'd0, led1}, 32'd0);
        wait_idle();

        // abort during the first drain
        start();
        repeat (9) step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("abort_led", {16'd0, led1}, 32'd0);
        check("abort_busy", {31'd0, busy1}, 32'd0);
        check("abort_lit", {27'd0, lit1}, 32'd0);
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done1) dones++;
        end
        check("abort_no_done", dones, 0);
        wait_idle();

        // stop landing on the final flash toggle suppresses done
        start();
        repeat (35) step();
        check("stopfin_led_k35", {16'd0, led1}, 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stopfin_led", {16'd0, led1}, 32'd0);
        check("stopfin_busy", {31'd0, busy1}, 32'd0);
        check("stopfin_done", {31'd0, done1}, 32'd0);
        step();
        check("stopfin_done_next", {31'd0, done1}, 32'd0);
        wait_idle();

        // reset in the middle of a fill
        start();
        repeat (5) step();
        check("midrst_led_pre", {16'd0, led1}, 32'h0000001F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_led", {16'd0, led1}, 32'd0);
        check("midrst_busy", {31'd0, busy1}, 32'd0);
        check("midrst_lit", {27'd0, lit1}, 32'd0);
        step();
        check("midrst_idle", {31'd0, busy1}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
